// File: rtl/mux2_1.sv
// Registered 4-to-1 single-bit selector with output-valid flag and select-change strobe.
// Qualifies the sampled bit for the classwork datapath blocks downstream.
module mux2_1 #(
    parameter int unsigned N_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_IN-1:0]         i,
    input  logic [$clog2(N_IN)-1:0] s,
    output logic                    y,
    output logic                    y_valid,
    output logic                    sel_chg
);

    localparam int unsigned SEL_W = $clog2(N_IN);

    logic [SEL_W-1:0] s_q;
    logic             sel_bit;
    logic             sel_diff;

    // Every 2-bit code addresses a real input, so no default path is needed.
    assign sel_bit  = i[s];
    assign sel_diff = (s != s_q);

    // sel_chg stays low until a previous capture exists to compare against.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= 1'b0;
            y_valid <= 1'b0;
            sel_chg <= 1'b0;
            s_q     <= SEL_W'(0);
        end else if (en) begin
            y       <= sel_bit;
            s_q     <= s;
            y_valid <= 1'b1;
            sel_chg <= y_valid && sel_diff;
        end else begin
            sel_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_1.sv
// Directed self-checking bench for mux2_1: reset, select sweep, hold, repeated select,
// mid-run async reset and an exhaustive i x s sweep.
module tb_mux2_1;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] i;
    logic [1:0] s;
    logic       y;
    logic       y_valid;
    logic       sel_chg;

    int n_cmp = 0;
    int n_err = 0;

    mux2_1 #(.N_IN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i       (i),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic ey, input logic ev, input logic ec);
        check({tag, ".y"}, y, ey);
        check({tag, ".y_valid"}, y_valid, ev);
        check({tag, ".sel_chg"}, sel_chg, ec);
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] iv;
        logic [1:0] sv;
        logic [1:0] prev_s;
        logic       exp_y;

        // Reset asserted with inputs that would otherwise capture a 1
        rst = 1'b1; en = 1'b1; i = 4'b1111; s = 2'b11;
        #1;
        check3("reset_now", 1'b0, 1'b0, 1'b0);
        tick();
        check3("reset_held1", 1'b0, 1'b0, 1'b0);
        tick();
        check3("reset_held2", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Select sweep over i=0110
        i = 4'b0110; s = 2'b00;
        tick(); check3("sweep_s00", 1'b0, 1'b1, 1'b0);
        s = 2'b01;
        tick(); check3("sweep_s01", 1'b1, 1'b1, 1'b1);
        s = 2'b10;
        tick(); check3("sweep_s10", 1'b1, 1'b1, 1'b1);
        s = 2'b11;
        tick(); check3("sweep_s11", 1'b0, 1'b1, 1'b1);

        // Async reset pulse between edges
        #2 rst = 1'b1;
        #1;
        check3("async_reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        s = 2'b11; i = 4'b1000;
        tick(); check3("first_after_reset", 1'b1, 1'b1, 1'b0);

        // Hold: load y=1, then disable and disturb inputs
        i = 4'b0110; s = 2'b01;
        tick(); check3("hold_load", 1'b1, 1'b1, 1'b1);
        en = 1'b0; i = 4'b1001; s = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick(); check3("hold", 1'b1, 1'b1, 1'b0);
        end

        // Repeated select with toggling data
        en = 1'b1; s = 2'b10; i = 4'b0100;
        tick(); check3("repeat1", 1'b1, 1'b1, 1'b1);
        i = 4'b0000;
        tick(); check3("repeat2", 1'b0, 1'b1, 1'b0);
        i = 4'b0100;
        tick(); check3("repeat3", 1'b1, 1'b1, 1'b0);

        // Exhaustive i x s
        prev_s = 2'b10;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                iv = 4'(a);
                sv = 2'(b);
                exp_y = iv[sv];
                i = iv; s = sv;
                tick();
                check("exh.y", y, exp_y);
                check("exh.sel_chg", sel_chg, sv != prev_s);
                prev_s = sv;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
